fetch_mem_sequencer: RTL
========================

Name: fetch_mem_sequencer

Overview:
Sequences the single-port synchronous instruction/data RAM between instruction fetch and the memory stage.
Fetches one- or two-word instructions (opcode + 16-bit immediate/EA word) and presents an {instr, imm} bundle to decode with a valid/ready handshake.
Grants the port to memory-stage push/pop/LDD/STD/LDM data accesses with priority over fetch.
Sits between the PC/fetch stage, the decode stage (which feeds control_unit), and the RAM.

Parameters:
ADDR_W, 11, RAM word-address width; pc and all addresses wrap modulo 2^ADDR_W
RESET_PC, 0, fetch address loaded on reset

Ports:
clk  in  1  rising-edge clock (the only clock)
rst  in  1  synchronous, active-high reset
pc_load  in  1  redirect: flush fetch, pc <= pc_in
pc_in  in  ADDR_W  redirect target
id_ready  in  1  decode accepts bundle
id_valid  out  1  bundle valid
id_instr  out  16  instruction word
id_imm  out  16  second word; 0 for one-word instructions
id_has_imm  out  1  bundle is two-word
id_pc  out  ADDR_W  address of instruction word
pc_out  out  ADDR_W  next fetch address
dm_rd  in  1  data read request (single cycle, always granted)
dm_wr  in  1  data write request (single cycle, always granted)
dm_addr  in  ADDR_W  data address
dm_wdata  in  16  write data
dm_rvalid  out  1  read data valid
dm_rdata  out  16  read data
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  16  RAM write data
ram_rdata  in  16  RAM read data, valid 1 cycle after read strobe

Behaviour:
- Reset (sync): pc=RESET_PC, state ISSUE1, return tag NONE, id_valid=0, id_instr=id_imm=0, id_has_imm=0, id_pc=0, dm_rvalid=0.
- RAM strobes are combinational from state and inputs. With no access, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Port arbitration, one access per cycle:
  - dm_rd|dm_wr: data wins. ram_en=1, ram_we=dm_wr, ram_addr=dm_addr, ram_wdata=dm_wdata.
  - Otherwise, in ISSUE1/ISSUE2 with no pc_load: fetch at pc, pc<=pc+1 (wraps).
  - dm_rd and dm_wr both high: write performed, no dm_rvalid.
- Return tag register {NONE, DATA, F1, F2} records each read issued.
  - Tag DATA: next cycle dm_rvalid=1, dm_rdata=ram_rdata. dm_rdata=0 when dm_rvalid=0.
- Fetch FSM:
  - ISSUE1: issue word1 when port free, then WAIT1; stays while data occupies the port.
  - WAIT1: capture instr and id_pc. Opcode instr[15:11] in TWO_WORD_OPS -> ISSUE2; otherwise id_valid<=1, id_imm<=0 -> HOLD.
  - ISSUE2: issue word2, then WAIT2.
  - WAIT2: capture id_imm, id_has_imm<=1, id_valid<=1 -> HOLD.
  - HOLD: on id_valid&id_ready, id_valid<=0 and ISSUE1. The next word1 issues in the following cycle; no prefetch while HOLD.
- Throughput with no data traffic: one-word instruction every 3 cycles, two-word every 5. Each data access delays a pending issue by 1 cycle.
- pc_load has priority over all fetch activity:
  - pc<=pc_in, state ISSUE1, id_valid<=0.
  - An in-flight F1/F2 tag is cleared and its return discarded; no fetch issues that cycle.
  - Data accesses and DATA tags are unaffected.
- pc_load while HOLD with id_ready=1: bundle counts as accepted, then flushed.
- pc_out = pc register.
- id_* outputs stable while id_valid & ~id_ready.

Decomposition:
- Shared package: opcode field range [15:11], TWO_WORD_OPS = {00111 LDM, 01110 LDD, 01111 STD, 10100, 10101 shift-imm}.
- Shared package: FSM state enum, return tag enum.
- One natural sub-module: port_arbiter (combinational grant/mux plus tag register). The FSM stays in the top module.

Test Plan:
- Reset, then one-word instr 0x0800 at addr 0: ram_addr=0 at cycle 1, id_valid at cycle 3 with id_instr=0x0800, id_has_imm=0, id_pc=0, pc_out=1.
- LDM 0x3900 at 4, imm 0x1234 at 5, id_ready=1: bundle id_instr=0x3900, id_imm=0x1234, id_has_imm=1, id_pc=4; next fetch at 6.
- dm_rd addr 0x7FF in same cycle as ISSUE1: RAM sees 0x7FF; fetch delayed 1 cycle; dm_rvalid next cycle with RAM content; no id_valid corruption.
- dm_rd=dm_wr=1, addr 0x10, wdata 0xBEEF: ram_we=1, dm_rvalid stays 0; later read of 0x10 returns 0xBEEF.
- pc_load=1, pc_in=0x200 during WAIT2: bundle never becomes valid; next ram_addr fetch is 0x200; pc_out wraps 0x7FF->0x000.
- id_ready=0 for 5 cycles in HOLD: id_* stable, no fetch ram_en; rst mid-HOLD clears id_valid next edge.

Source files
------------

// File: rtl/fetch_mem_sequencer_pkg.sv
// Shared types for the fetch/memory sequencer: opcode field, fetch FSM states,
// RAM return tags and the two-word opcode decoder.
package fetch_mem_sequencer_pkg;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 11;

  typedef enum logic [2:0] {
    ST_ISSUE1 = 3'd0,
    ST_WAIT1  = 3'd1,
    ST_ISSUE2 = 3'd2,
    ST_WAIT2  = 3'd3,
    ST_HOLD   = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DATA = 2'd1,
    TAG_F1   = 2'd2,
    TAG_F2   = 2'd3
  } ret_tag_e;

  // LDM, LDD, STD and the two shift-immediate forms carry a second word
  function automatic logic is_two_word(input logic [15:0] instr);
    logic [4:0] opc;
    opc = instr[OPC_MSB:OPC_LSB];
    case (opc)
      5'b00111, 5'b01110, 5'b01111, 5'b10100, 5'b10101: is_two_word = 1'b1;
      default:                                          is_two_word = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_mem_sequencer_port_arbiter.sv
// Single-port RAM arbiter: data accesses win over fetch; a tag register
// remembers what the previous cycle's read was for.
module fetch_mem_sequencer_port_arbiter
  import fetch_mem_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [15:0]       dm_wdata,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  ret_tag_e          fetch_tag,
  output logic              fetch_gnt,
  output logic              dm_rvalid,
  output logic [15:0]       dm_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata
);

  ret_tag_e tag_q;
  ret_tag_e tag_d;

  // grant and RAM strobe mux; a write-with-read is a pure write, so no DATA tag
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 16'h0000;
    fetch_gnt = 1'b0;
    tag_d     = TAG_NONE;
    if (dm_rd || dm_wr) begin
      ram_en    = 1'b1;
      ram_we    = dm_wr;
      ram_addr  = dm_addr;
      ram_wdata = dm_wdata;
      tag_d     = dm_wr ? TAG_NONE : TAG_DATA;
    end else if (fetch_req) begin
      ram_en    = 1'b1;
      ram_addr  = fetch_addr;
      fetch_gnt = 1'b1;
      tag_d     = fetch_tag;
    end else begin
      tag_d     = TAG_NONE;
    end
  end

  // return tag register
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= TAG_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  // data read return
  always_comb begin
    dm_rvalid = (tag_q == TAG_DATA);
    if (dm_rvalid) begin
      dm_rdata = ram_rdata;
    end else begin
      dm_rdata = 16'h0000;
    end
  end

endmodule

// File: rtl/fetch_mem_sequencer.sv
// Instruction fetch sequencer sharing one RAM port with the memory stage;
// builds {instr, imm} bundles for decode behind a valid/ready handshake.
module fetch_mem_sequencer
  import fetch_mem_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [15:0]       id_instr,
  output logic [15:0]       id_imm,
  output logic              id_has_imm,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [15:0]       dm_wdata,
  output logic              dm_rvalid,
  output logic [15:0]       dm_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata
);

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [15:0]       id_instr_q, id_instr_d;
  logic [15:0]       id_imm_q, id_imm_d;
  logic              id_valid_q, id_valid_d;
  logic              id_has_imm_q, id_has_imm_d;
  logic              fetch_req;
  logic              fetch_gnt;
  ret_tag_e          fetch_tag;

  fetch_mem_sequencer_port_arbiter #(.ADDR_W(ADDR_W)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .dm_rd      (dm_rd),
    .dm_wr      (dm_wr),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .fetch_req  (fetch_req),
    .fetch_addr (pc_q),
    .fetch_tag  (fetch_tag),
    .fetch_gnt  (fetch_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // fetch FSM next state; a redirect overrides everything including returns
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;
    id_imm_d     = id_imm_q;
    id_valid_d   = id_valid_q;
    id_has_imm_d = id_has_imm_q;
    fetch_req    = ((state_q == ST_ISSUE1) || (state_q == ST_ISSUE2)) && !pc_load && !rst;
    fetch_tag    = (state_q == ST_ISSUE2) ? TAG_F2 : TAG_F1;
    if (pc_load) begin
      pc_d       = pc_in;
      state_d    = ST_ISSUE1;
      id_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ISSUE1, ST_ISSUE2: begin
          if (fetch_gnt) begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = (state_q == ST_ISSUE2) ? ST_WAIT2 : ST_WAIT1;
          end else begin
            state_d = state_q;
          end
        end
        ST_WAIT1: begin
          id_instr_d   = ram_rdata;
          id_pc_d      = pc_q - ADDR_W'(1);
          id_imm_d     = 16'h0000;
          id_has_imm_d = 1'b0;
          if (is_two_word(ram_rdata)) begin
            state_d = ST_ISSUE2;
          end else begin
            id_valid_d = 1'b1;
            state_d    = ST_HOLD;
          end
        end
        ST_WAIT2: begin
          id_imm_d     = ram_rdata;
          id_has_imm_d = 1'b1;
          id_valid_d   = 1'b1;
          state_d      = ST_HOLD;
        end
        ST_HOLD: begin
          if (id_ready) begin
            id_valid_d = 1'b0;
            state_d    = ST_ISSUE1;
          end else begin
            state_d    = ST_HOLD;
          end
        end
        default: begin
          id_valid_d = 1'b0;
          state_d    = ST_ISSUE1;
        end
      endcase
    end
  end

  // state and bundle registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ISSUE1;
      pc_q         <= RESET_PC_V;
      id_pc_q      <= '0;
      id_instr_q   <= 16'h0000;
      id_imm_q     <= 16'h0000;
      id_valid_q   <= 1'b0;
      id_has_imm_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
      id_imm_q     <= id_imm_d;
      id_valid_q   <= id_valid_d;
      id_has_imm_q <= id_has_imm_d;
    end
  end

  assign id_valid   = id_valid_q;
  assign id_instr   = id_instr_q;
  assign id_imm     = id_imm_q;
  assign id_has_imm = id_has_imm_q;
  assign id_pc      = id_pc_q;
  assign pc_out     = pc_q;

endmodule
